// File: rtl/m68k_bus_responder.sv
// 68000 bus slave for one decoded address window: bridges each CPU bus cycle to a
// single-beat req/ack backend, adds programmable wait states and a no-ack timeout.
module m68k_bus_responder #(
    parameter logic [23:0] BASE        = 24'h000000,
    parameter logic [23:0] MASK        = 24'hF00000,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        CLK_68KCLK,
    input  logic        RESET,
    input  logic [23:1] M68K_ADDR,
    input  logic [15:0] M68K_DOUT,
    input  logic        nAS,
    input  logic        nUDS,
    input  logic        nLDS,
    input  logic        M68K_RW,
    output logic        nDTACK,
    output logic [15:0] M68K_DIN,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [23:1] MEM_ADDR,
    output logic [1:0]  MEM_BE,
    output logic [15:0] MEM_WDATA,
    input  logic [15:0] MEM_RDATA,
    input  logic        MEM_ACK,
    output logic        TIMEOUT_ERR
);

    // state | meaning
    // IDLE  | no cycle in progress, waiting for a decoded strobe
    // REQ   | backend request outstanding, timeout counter running
    // WAIT  | backend done, counting down programmed wait states
    // ACK   | nDTACK driven low until the CPU releases nAS
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } state_t;

    localparam logic [3:0] WS_INIT  = 4'(WAIT_STATES);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_d;
    logic [7:0]  tmo_cnt, tmo_cnt_d;
    logic [3:0]  wait_cnt, wait_cnt_d;
    logic        aborted, aborted_d;
    logic        rw_q, rw_d;
    logic [15:0] rd_hold, rd_hold_d;

    logic        dtack_d;
    logic [15:0] din_d;
    logic        req_d;
    logic        we_d;
    logic [23:1] addr_d;
    logic [1:0]  be_d;
    logic [15:0] wdata_d;
    logic        terr_d;

    logic [23:0] byte_addr;
    logic        hit;
    logic        start;
    logic        abort_now;

    assign byte_addr = {M68K_ADDR, 1'b0};
    assign hit       = (byte_addr & MASK) == (BASE & MASK);
    assign start     = !nAS && hit && (!nUDS || !nLDS);
    // an abort seen on any earlier REQ cycle stays pending until the backend answers
    assign abort_now = aborted || nAS;

    always_ff @(posedge CLK_68KCLK) begin
        if (RESET) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            wait_cnt    <= '0;
            aborted     <= 1'b0;
            rw_q        <= 1'b0;
            rd_hold     <= '0;
            nDTACK      <= 1'b1;
            M68K_DIN    <= 16'h0000;
            MEM_REQ     <= 1'b0;
            MEM_WE      <= 1'b0;
            MEM_ADDR    <= '0;
            MEM_BE      <= '0;
            MEM_WDATA   <= '0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            state       <= state_d;
            tmo_cnt     <= tmo_cnt_d;
            wait_cnt    <= wait_cnt_d;
            aborted     <= aborted_d;
            rw_q        <= rw_d;
            rd_hold     <= rd_hold_d;
            nDTACK      <= dtack_d;
            M68K_DIN    <= din_d;
            MEM_REQ     <= req_d;
            MEM_WE      <= we_d;
            MEM_ADDR    <= addr_d;
            MEM_BE      <= be_d;
            MEM_WDATA   <= wdata_d;
            TIMEOUT_ERR <= terr_d;
        end
    end

    always_comb begin
        state_d    = state;
        tmo_cnt_d  = tmo_cnt;
        wait_cnt_d = wait_cnt;
        aborted_d  = aborted;
        rw_d       = rw_q;
        rd_hold_d  = rd_hold;
        dtack_d    = nDTACK;
        din_d      = M68K_DIN;
        req_d      = MEM_REQ;
        we_d       = MEM_WE;
        addr_d     = MEM_ADDR;
        be_d       = MEM_BE;
        wdata_d    = MEM_WDATA;
        terr_d     = 1'b0;

        unique case (state)
            IDLE: begin
                dtack_d = 1'b1;
                if (start) begin
                    state_d   = REQ;
                    req_d     = 1'b1;
                    we_d      = !M68K_RW;
                    rw_d      = M68K_RW;
                    addr_d    = M68K_ADDR;
                    be_d      = {!nUDS, !nLDS};
                    wdata_d   = M68K_DOUT;
                    tmo_cnt_d = '0;
                    aborted_d = 1'b0;
                end
            end

            REQ: begin
                if (MEM_ACK) begin
                    // ack beats a timeout expiring on the same edge
                    req_d     = 1'b0;
                    tmo_cnt_d = '0;
                    aborted_d = 1'b0;
                    if (abort_now) begin
                        state_d = IDLE;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ACK;
                        if (rw_q) din_d = MEM_RDATA;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = WS_INIT;
                        rd_hold_d  = MEM_RDATA;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    req_d     = 1'b0;
                    terr_d    = 1'b1;
                    tmo_cnt_d = '0;
                    aborted_d = 1'b0;
                    if (abort_now) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ACK;
                        if (rw_q) din_d = 16'hFFFF;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt + 8'd1;
                    aborted_d = abort_now;
                end
            end

            WAIT: begin
                // read data is held back until the wait expires so an abort here leaves M68K_DIN untouched
                if (nAS) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt <= 4'd1) begin
                    state_d    = ACK;
                    wait_cnt_d = '0;
                    if (rw_q) din_d = rd_hold;
                end else begin
                    wait_cnt_d = wait_cnt - 4'd1;
                end
            end

            ACK: begin
                if (nAS) begin
                    dtack_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    dtack_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                dtack_d = 1'b1;
                req_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Bench for m68k_bus_responder: two instances (no wait/short timeout, 2 waits/longer timeout)
// share one CPU/backend stimulus; each is checked against a transaction-level prediction.
module tb_m68k_bus_responder;

    localparam int WS_A = 0;
    localparam int TO_A = 8;
    localparam int WS_B = 2;
    localparam int TO_B = 12;
    localparam int LIMIT = 30;

    logic        clk;
    logic        rst;
    logic [23:1] m_addr;
    logic [15:0] m_dout;
    logic        as_n, uds_n, lds_n, rw;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    logic        dtack_a, req_a, we_a, terr_a;
    logic [15:0] din_a, wdata_a;
    logic [23:1] addr_a;
    logic [1:0]  be_a;
    logic        dtack_b, req_b, we_b, terr_b;
    logic [15:0] din_b, wdata_b;
    logic [23:1] addr_b;
    logic [1:0]  be_b;

    int checks = 0;
    int failures = 0;

    logic [15:0] din_a_m, din_b_m;
    logic [23:1] f_addr;
    logic [1:0]  f_be;
    logic        f_we;
    logic [15:0] f_wdata;

    m68k_bus_responder #(.BASE(24'h000000), .MASK(24'hF00000), .WAIT_STATES(WS_A), .TIMEOUT(TO_A)) dut_a (
        .CLK_68KCLK(clk), .RESET(rst), .M68K_ADDR(m_addr), .M68K_DOUT(m_dout),
        .nAS(as_n), .nUDS(uds_n), .nLDS(lds_n), .M68K_RW(rw),
        .nDTACK(dtack_a), .M68K_DIN(din_a), .MEM_REQ(req_a), .MEM_WE(we_a),
        .MEM_ADDR(addr_a), .MEM_BE(be_a), .MEM_WDATA(wdata_a),
        .MEM_RDATA(mem_rdata), .MEM_ACK(mem_ack), .TIMEOUT_ERR(terr_a)
    );

    m68k_bus_responder #(.BASE(24'h000000), .MASK(24'hF00000), .WAIT_STATES(WS_B), .TIMEOUT(TO_B)) dut_b (
        .CLK_68KCLK(clk), .RESET(rst), .M68K_ADDR(m_addr), .M68K_DOUT(m_dout),
        .nAS(as_n), .nUDS(uds_n), .nLDS(lds_n), .M68K_RW(rw),
        .nDTACK(dtack_b), .M68K_DIN(din_b), .MEM_REQ(req_b), .MEM_WE(we_b),
        .MEM_ADDR(addr_b), .MEM_BE(be_b), .MEM_WDATA(wdata_b),
        .MEM_RDATA(mem_rdata), .MEM_ACK(mem_ack), .TIMEOUT_ERR(terr_b)
    );

    initial clk = 1'b0;
    always #5 clk = !clk;

    typedef struct {
        logic [23:1] addr;
        logic        uds_n;
        logic        lds_n;
        logic        rw;
        logic [15:0] wdata;
        int          d;       // ack edge after start, 0 = backend never acks
        logic [15:0] rdata;
    } stim_t;

    typedef struct {
        int          low;     // first edge with nDTACK low, -1 = never
        int          req;     // sampled cycles with MEM_REQ high
        int          terr;    // TIMEOUT_ERR pulses
        logic [15:0] din;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  a;
        exp_t  b;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic decode_hit(input logic [23:1] a);
        logic [23:0] b;
        b = {a, 1'b0};
        return (b & 24'hF00000) == 24'h000000;
    endfunction

    function automatic exp_t model(input stim_t s, input int ws, input int tmo, input logic [15:0] prev);
        exp_t e;
        if (!(decode_hit(s.addr) && (!s.uds_n || !s.lds_n))) begin
            e.low = -1; e.req = 0; e.terr = 0; e.din = prev;
        end else if (s.d != 0 && s.d <= tmo) begin
            e.low = s.d + 1 + ws; e.req = s.d; e.terr = 0; e.din = s.rw ? s.rdata : prev;
        end else begin
            e.low = tmo + 1; e.req = tmo; e.terr = 1; e.din = s.rw ? 16'hFFFF : prev;
        end
        return e;
    endfunction

    task automatic check_fields(input string tag);
        chk({tag, "_addr_a"}, int'(addr_a), int'(f_addr));
        chk({tag, "_be_a"}, int'(be_a), int'(f_be));
        chk({tag, "_we_a"}, int'(we_a), int'(f_we));
        chk({tag, "_wdata_a"}, int'(wdata_a), int'(f_wdata));
        chk({tag, "_addr_b"}, int'(addr_b), int'(f_addr));
        chk({tag, "_be_b"}, int'(be_b), int'(f_be));
    endtask

    task automatic run_txn(input stim_t s, input exp_t ea, input exp_t eb, input string tag);
        int la, lb, ra, rb, ta, tb;
        la = -1; lb = -1; ra = 0; rb = 0; ta = 0; tb = 0;
        m_addr = s.addr; m_dout = s.wdata; rw = s.rw;
        uds_n = s.uds_n; lds_n = s.lds_n; mem_rdata = s.rdata;
        mem_ack = 1'b0; as_n = 1'b0;
        for (int n = 0; n <= LIMIT; n++) begin
            @(posedge clk); #1;
            if (!dtack_a && la < 0) la = n;
            if (!dtack_b && lb < 0) lb = n;
            if (req_a) ra++;
            if (req_b) rb++;
            if (terr_a) ta++;
            if (terr_b) tb++;
            if (la >= 0 && lb >= 0) break;
            mem_ack = (s.d != 0) && (n + 1 == s.d);
        end
        mem_ack = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_release_a"}, int'(dtack_a), 1);
        chk({tag, "_release_b"}, int'(dtack_b), 1);
        chk({tag, "_low_a"}, la, ea.low);
        chk({tag, "_low_b"}, lb, eb.low);
        chk({tag, "_req_a"}, ra, ea.req);
        chk({tag, "_req_b"}, rb, eb.req);
        chk({tag, "_terr_a"}, ta, ea.terr);
        chk({tag, "_terr_b"}, tb, eb.terr);
        chk({tag, "_din_a"}, int'(din_a), int'(ea.din));
        chk({tag, "_din_b"}, int'(din_b), int'(eb.din));
        if (decode_hit(s.addr) && (!s.uds_n || !s.lds_n)) begin
            f_addr = s.addr; f_be = {!s.uds_n, !s.lds_n}; f_we = !s.rw; f_wdata = s.wdata;
        end
        check_fields(tag);
        din_a_m = ea.din;
        din_b_m = eb.din;
        @(posedge clk); #1;
    endtask

    vec_t  tbl[8];
    stim_t s;
    exp_t  ea, eb;

    initial begin
        //         addr      uds  lds  rw  wdata     d   rdata        low req terr din      (a then b)
        tbl[0] = '{'{23'h000080, 1'b0, 1'b0, 1'b1, 16'h0000, 3, 16'hBEEF}, '{4, 3, 0, 16'hBEEF}, '{6, 3, 0, 16'hBEEF}};
        tbl[1] = '{'{23'h000101, 1'b1, 1'b0, 1'b0, 16'h1234, 2, 16'h0000}, '{3, 2, 0, 16'hBEEF}, '{5, 2, 0, 16'hBEEF}};
        tbl[2] = '{'{23'h000040, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'h0000}, '{9, 8, 1, 16'hFFFF}, '{13, 12, 1, 16'hFFFF}};
        tbl[3] = '{'{23'h100000, 1'b0, 1'b0, 1'b1, 16'h5555, 0, 16'h0000}, '{-1, 0, 0, 16'hFFFF}, '{-1, 0, 0, 16'hFFFF}};
        tbl[4] = '{'{23'h000050, 1'b1, 1'b1, 1'b1, 16'h6666, 0, 16'h0000}, '{-1, 0, 0, 16'hFFFF}, '{-1, 0, 0, 16'hFFFF}};
        tbl[5] = '{'{23'h000060, 1'b0, 1'b1, 1'b1, 16'h0000, 8, 16'h5A5A}, '{9, 8, 0, 16'h5A5A}, '{11, 8, 0, 16'h5A5A}};
        tbl[6] = '{'{23'h000070, 1'b0, 1'b0, 1'b1, 16'h0000, 10, 16'h1111}, '{9, 8, 1, 16'hFFFF}, '{13, 10, 0, 16'h1111}};
        tbl[7] = '{'{23'h000090, 1'b0, 1'b0, 1'b0, 16'hCAFE, 1, 16'h9999}, '{2, 1, 0, 16'hFFFF}, '{4, 1, 0, 16'h1111}};

        rst = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
        m_addr = '0; m_dout = '0; mem_rdata = '0; mem_ack = 1'b0;
        f_addr = '0; f_be = '0; f_we = 1'b0; f_wdata = '0;
        din_a_m = 16'h0000; din_b_m = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dtack_a", int'(dtack_a), 1);
        chk("reset_dtack_b", int'(dtack_b), 1);
        chk("reset_req_a", int'(req_a), 0);
        chk("reset_din_a", int'(din_a), 0);
        chk("reset_terr_b", int'(terr_b), 0);
        check_fields("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_txn(tbl[i].s, tbl[i].a, tbl[i].b, $sformatf("vec%0d", i));

        // abort in REQ: nAS released before edge 2, backend acks at edge 7
        begin
            int ra, rb, lows, terrs;
            ra = 0; rb = 0; lows = 0; terrs = 0;
            m_addr = 23'h000010; m_dout = 16'h0000; rw = 1'b1; mem_rdata = 16'h7777;
            uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0; mem_ack = 1'b0;
            for (int n = 0; n <= 9; n++) begin
                @(posedge clk); #1;
                if (req_a) ra++;
                if (req_b) rb++;
                if (!dtack_a || !dtack_b) lows++;
                if (terr_a || terr_b) terrs++;
                if (n == 1) begin as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; end
                mem_ack = (n + 1 == 7);
            end
            mem_ack = 1'b0;
            chk("abort_req_a", ra, 7);
            chk("abort_req_b", rb, 7);
            chk("abort_dtack", lows, 0);
            chk("abort_terr", terrs, 0);
            chk("abort_din_a", int'(din_a), int'(din_a_m));
            chk("abort_din_b", int'(din_b), int'(din_b_m));
            f_addr = 23'h000010; f_be = 2'b11; f_we = 1'b0; f_wdata = 16'h0000;
            check_fields("abort");
        end

        // reset in the middle of REQ, then a stale ack that must be ignored
        m_addr = 23'h000020; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midreq_active", int'(req_a && req_b), 1);
        rst = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_req_a", int'(req_a), 0);
        chk("midrst_req_b", int'(req_b), 0);
        chk("midrst_dtack_a", int'(dtack_a), 1);
        chk("midrst_din_a", int'(din_a), 0);
        chk("midrst_din_b", int'(din_b), 0);
        rst = 1'b0; mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("stale_ack_req", int'(req_a || req_b), 0);
        chk("stale_ack_dtack", int'(dtack_a && dtack_b), 1);
        chk("stale_ack_terr", int'(terr_a || terr_b), 0);
        din_a_m = 16'h0000; din_b_m = 16'h0000;
        f_addr = '0; f_be = '0; f_we = 1'b0; f_wdata = '0;
        s = '{23'h000030, 1'b0, 1'b0, 1'b1, 16'h0000, 2, 16'h4242};
        ea = model(s, WS_A, TO_A, din_a_m);
        eb = model(s, WS_B, TO_B, din_b_m);
        run_txn(s, ea, eb, "post_reset");

        for (int i = 0; i < 40; i++) begin
            int sp;
            s.addr  = {(($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0), 19'($urandom)};
            sp      = int'($urandom_range(0, 7));
            s.uds_n = (sp == 1) || (sp == 7);
            s.lds_n = (sp == 2) || (sp == 7);
            s.rw    = 1'($urandom);
            s.wdata = 16'($urandom);
            s.d     = int'($urandom_range(0, 14));
            s.rdata = 16'($urandom);
            ea = model(s, WS_A, TO_A, din_a_m);
            eb = model(s, WS_B, TO_B, din_b_m);
            run_txn(s, ea, eb, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
